// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, command bytes and frame builder.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] ACK_BYTE    = 8'hFA;

  // Index of the stop bit inside the 10-bit host frame.
  localparam logic [3:0] FRAME_STOP_IDX = 4'd9;

  // {stop, odd parity, data}; sent LSB first after the request-to-send start bit.
  function automatic logic [9:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the PS/2 clock and data pads plus clock falling-edge detect.
module ps2_line_sync (
  input  logic clk,
  input  logic clrn,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_s,
  output logic data_s,
  output logic clk_fe
);

  logic [1:0] clk_sync_q, clk_sync_d;
  logic [1:0] data_sync_q, data_sync_d;
  logic       clk_prev_q, clk_prev_d;

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], clk_in};
    data_sync_d = {data_sync_q[0], data_in};
    clk_prev_d  = clk_sync_q[1];
  end

  // Idle PS/2 lines are high, so the chain resets to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
    end
  end

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign clk_fe = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift 10 bits, check ACK.
//
// state     | meaning
// IDLE      | lines released, waiting for wr
// INHIBIT   | clock held low for INHIBIT_CYCLES
// RTS       | data pulled low (start bit), clock released
// SHIFT     | next frame bit driven on each device clock falling edge
// ACK       | stop bit released, sample device acknowledge on next fall
// WAIT_IDLE | wait for clock and data both high, then report
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       wr,
  input  logic [7:0] din,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] INH_LOAD = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_e    state_q, state_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [9:0]    frame_q, frame_d;
  logic          err_q, err_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ack_err_q, ack_err_d;
  logic          timeout_q, timeout_d;

  logic clk_s, data_s, clk_fe;

  ps2_line_sync u_sync (
    .clk     (clk),
    .clrn    (clrn),
    .clk_in  (ps2_clk_in),
    .data_in (ps2_data_in),
    .clk_s   (clk_s),
    .data_s  (data_s),
    .clk_fe  (clk_fe)
  );

  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    err_d     = err_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    ack_err_d = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (wr) begin
          frame_d   = ps2_frame(din);
          inh_cnt_d = INH_LOAD;
          err_d     = 1'b0;
          clk_oe_d  = 1'b1;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt_q == '0) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = RTS;
        end else begin
          inh_cnt_d = inh_cnt_q - IW'(1);
        end
      end
      RTS: begin
        idx_d     = 4'd0;
        tmo_cnt_d = '0;
        state_d   = SHIFT;
      end
      SHIFT, ACK, WAIT_IDLE: begin
        tmo_cnt_d = clk_fe ? '0 : tmo_cnt_q + TW'(1);
        if (state_q == SHIFT && clk_fe) begin
          data_oe_d = ~frame_q[idx_q];
          idx_d     = idx_q + 4'd1;
          if (idx_q == FRAME_STOP_IDX) state_d = ACK;
        end else if (state_q == ACK && clk_fe) begin
          err_d   = data_s;
          state_d = WAIT_IDLE;
        end else if (state_q == WAIT_IDLE && clk_s && data_s) begin
          done_d    = 1'b1;
          ack_err_d = err_q;
          state_d   = IDLE;
        end else if (!clk_fe && tmo_cnt_q == TMO_LAST) begin
          // Device stopped clocking: abandon the frame and free both lines.
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          timeout_d = 1'b1;
          tmo_cnt_d = '0;
          state_d   = IDLE;
        end
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= IDLE;
      inh_cnt_q <= '0;
      tmo_cnt_q <= '0;
      idx_q     <= 4'd0;
      frame_q   <= 10'd0;
      err_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inh_cnt_q <= inh_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      err_q     <= err_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      timeout_q <= timeout_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_err     = ack_err_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on the pads and a scoreboard of expected frame outcomes.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH_T = 100;
  localparam int TMO_T = 1500;
  localparam int HALF  = 40;

  typedef struct {
    logic [10:0] frame;
    logic        ack_err;
    logic        tmo;
  } exp_t;

  logic       clk, clrn, wr;
  logic [7:0] din;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, done, ack_err, timeout;
  logic       dev_clk, dev_data;

  logic [10:0] cap;
  exp_t        exp_q[$];
  exp_t        ev;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_fall_cyc = 0;
  int          delta;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH_T),
    .TIMEOUT_CYCLES (TMO_T)
  ) dut (
    .clk         (clk),
    .clrn        (clrn),
    .wr          (wr),
    .din         (din),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .ack_err     (ack_err),
    .timeout     (timeout)
  );

  // Open-drain pads: low if either side pulls low.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done/ack_err/timeout event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (clrn && (done || ack_err || timeout)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {29'd0, done, ack_err, timeout}, 32'd0);
      end else begin
        ev = exp_q.pop_front();
        check("done", 32'(done), 32'(!ev.tmo));
        check("ack_err", 32'(ack_err), 32'(ev.ack_err));
        check("timeout", 32'(timeout), 32'(ev.tmo));
        check("busy_at_end", 32'(busy), 32'd0);
        if (ev.tmo) begin
          delta = cyc - last_fall_cyc;
          check("timeout_latency_ok", 32'(delta >= TMO_T && delta <= TMO_T + 4), 32'd1);
          check("oe_at_timeout", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        end else begin
          check("frame_on_wire", 32'(cap), 32'(ev.frame));
        end
      end
    end
  end

  // mode 0: normal, 1: second wr during SHIFT, 2: clrn pulse during SHIFT.
  task automatic run_frame(input logic [7:0] b, input logic exp_par, input logic ack_low,
                           input int edges, input int mode);
    int n;
    exp_t e;
    cap = '0;
    e.frame   = {1'b1, exp_par, b, 1'b0};
    e.ack_err = ~ack_low;
    e.tmo     = (edges < 11);
    if (mode != 2) exp_q.push_back(e);

    @(negedge clk);
    din = b;
    wr  = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    check("busy_after_wr", 32'(busy), 32'd1);

    n = 0;
    while (ps2_clk_oe && n < INH_T * 4) begin
      if (ps2_data_oe) check("data_oe_in_inhibit", 32'(ps2_data_oe), 32'd0);
      n++;
      @(negedge clk);
    end
    check("inhibit_cycles", 32'(n), 32'(INH_T));
    check("rts_data_oe", 32'(ps2_data_oe), 32'd1);
    cap[0] = ps2_data_in;
    repeat (20) @(negedge clk);

    for (int k = 1; k <= edges; k++) begin
      if (k == 11) begin
        dev_data = ~ack_low;
        repeat (5) @(negedge clk);
      end
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (k <= 10) cap[k] = ps2_data_in;
      if (k == 9) check("parity_bit", 32'(cap[9]), 32'(exp_par));
      if (mode == 1 && k == 3) begin
        @(negedge clk);
        din = CMD_ENABLE;
        wr  = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        check("busy_during_ignored_wr", 32'(busy), 32'd1);
      end
      if (mode == 2 && k == 5) begin
        check("data_oe_before_reset", 32'(ps2_data_oe), 32'd1);
        @(negedge clk);
        clrn = 1'b0;
        #1;
        check("oe_after_async_reset", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("busy_after_async_reset", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        repeat (10) @(negedge clk);
        return;
      end
      repeat (HALF) @(negedge clk);
      if (k == 11) dev_data = 1'b1;
    end

    n = 0;
    while (busy && n < TMO_T * 2) begin
      n++;
      @(negedge clk);
    end
    check("busy_released", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    clrn     = 1'b0;
    wr       = 1'b0;
    din      = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {26'd0, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout}, 32'd0);
    clrn = 1'b1;
    repeat (5) @(negedge clk);

    run_frame(CMD_SET_LED, 1'b1, 1'b1, 11, 0);
    run_frame(8'h00,       1'b1, 1'b1, 11, 0);
    run_frame(8'h01,       1'b0, 1'b1, 11, 0);
    run_frame(CMD_SET_LED, 1'b1, 1'b0, 11, 0);
    run_frame(CMD_SET_LED, 1'b1, 1'b1, 4,  0);
    run_frame(CMD_SET_LED, 1'b1, 1'b1, 11, 1);
    run_frame(CMD_SET_LED, 1'b1, 1'b1, 11, 2);
    run_frame(CMD_RESET,   1'b1, 1'b1, 11, 0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: the opposite direction of the existing ps2_keyboard receiver.
- Lets the CPU send command bytes to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Drives the open-drain PS/2 clock and data lines through output enables; the top level builds the tri-state pads.
- Sits on the I/O bus next to ps2_keyboard. Its busy output gates the receiver so the keyboard's acknowledge does not corrupt an RX frame.

Parameters:
INHIBIT_CYCLES, 10000, clk cycles the PS/2 clock is held low before request-to-send (100 us at 100 MHz)
TIMEOUT_CYCLES, 2000000, max clk cycles between device clock falling edges before abort (20 ms at 100 MHz)

Ports:
clk  in  1  system clock
clrn  in  1  asynchronous active-low reset
wr  in  1  one-cycle write strobe; starts a transfer of din when idle
din  in  8  command byte
ps2_clk_in  in  1  sampled PS/2 clock pad (asynchronous)
ps2_data_in  in  1  sampled PS/2 data pad (asynchronous)
ps2_clk_oe  out  1  1 = pull PS/2 clock low, 0 = release
ps2_data_oe  out  1  1 = pull PS/2 data low, 0 = release
busy  out  1  high from the accepted wr until the state machine returns to IDLE
done  out  1  one-cycle pulse when the frame completes with a valid acknowledge
ack_err  out  1  one-cycle pulse with done when data is high at the ACK edge
timeout  out  1  one-cycle pulse on timeout abort; done does not pulse

Behaviour:
- Reset (clrn=0, asynchronous): state IDLE, all outputs 0, counters 0, shift register 0, synchronisers set to 1.
- Inputs: ps2_clk_in and ps2_data_in each pass a 2-FF synchroniser. A falling edge (fe) is prev=1 and now=0 on the synchronised clock. Edge-to-response latency is 3 clk.
- Frame: latched at the accepted wr as {stop=1, parity=~^din (odd), din[7:0] LSB first}. The start bit is the request-to-send data low.
- IDLE: both oe=0, busy=0. If wr=1, latch the frame, go to INHIBIT, busy=1 next cycle. wr while busy is ignored; no queueing.
- INHIBIT: clk_oe=1, data_oe=0. Counts INHIBIT_CYCLES, then goes to RTS.
- RTS: in one cycle, data_oe=1 and clk_oe=0, so data goes low before the clock is released. Go to SHIFT with bit index 0 and the timeout counter cleared.
- SHIFT: on each fe, data_oe = ~frame[idx], idx++.
  - Edges 1-8 put d0..d7 on the line; edge 9 puts parity.
  - Edge 10 releases data (stop bit = 1) and moves to ACK.
- ACK: on the next fe (edge 11), sample ps2_data_in. Low means a good acknowledge; high sets an internal error flag. Go to WAIT_IDLE.
- WAIT_IDLE: wait for synchronised clock and data both high. Then pulse done, pulse ack_err if the flag is set, and go to IDLE. busy falls in the same cycle done pulses.
- Timeout:
  - The counter runs in SHIFT, ACK and WAIT_IDLE and clears on every fe.
  - At TIMEOUT_CYCLES-1 it releases both oe, pulses timeout, and returns to IDLE.
  - The count covers the device's first-clock delay after RTS.
- fe and timeout terminal count in the same cycle: fe wins and the counter clears.
- Glitches: a clock low pulse shorter than 2 clk may be missed. Filtering is the pad's job.
- clrn asserted mid-frame: both oe released immediately (asynchronously). No done or timeout pulse.
- Counter widths:
  - INHIBIT counter: clog2(INHIBIT_CYCLES) bits.
  - Timeout counter: clog2(TIMEOUT_CYCLES) bits.
  - idx: 4 bits, range 0..10.
- oe outputs are registered, with no combinational path from the inputs.

Decomposition:
- Shared package ps2_pkg holds:
  - state encoding localparams: IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE;
  - PS/2 command constants: CMD_SET_LED=8'hED, CMD_ECHO=8'hEE, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF;
  - ACK_BYTE=8'hFA.
- One sub-module, ps2_line_sync: 2-FF synchroniser plus falling-edge detect. It is reusable by ps2_keyboard.

Test Plan:
1. wr with din=8'hED; device model clocks 11 edges at a 30 us period and drives ack low.
   - clk_oe held low exactly 10000 cycles.
   - Bits sampled on rising edges are 0,1,0,1,1,0,1,1,1, parity 1, stop 1.
   - done pulses once, ack_err=0, busy low afterwards.
2. din=8'h00 → parity bit = 1. din=8'h01 → parity bit = 0. Both checked at edge 9.
3. Device leaves data high at edge 11 → done=1 and ack_err=1 in the same cycle, then IDLE.
4. Device stops clocking after edge 4 → timeout pulses 2000000 cycles after the last fe, both oe=0, done never pulses.
5. A second wr (din=8'hF4) issued during SHIFT is ignored; the frame on the wire stays 8'hED.
6. clrn pulsed low during SHIFT → ps2_clk_oe and ps2_data_oe drop within the same cycle, busy=0. A subsequent wr of 8'hFF completes normally.
